// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle DIV/DIVU controller and datapath for the EX stage.
//
// A restoring shift-subtract divider runs one iteration per clock for
// DATA_W iterations. It stalls the pipeline while the division is in
// flight. The quotient is delivered on result_lo and the remainder on
// result_hi, both qualified by result_ready.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   start          EX holds a valid DIV/DIVU
//   signed_div     1 = DIV, 0 = DIVU (sampled with start)
//   opdata1        dividend (rs)
//   opdata2        divisor (rt)
//   flush          exception/ERET flush; abandons any division
//   hold           downstream hold; keeps the result presented in DONE
//   stall_div      stall request to the hazard unit
//   result_hi      remainder
//   result_lo      quotient
//   result_ready   result valid / HI-LO write qualifier
//   perf_stall_cnt (only with DIV_CTRL_PERF_CNT_EN) saturating count of
//                  stall cycles
//
// Optional feature macro: DIV_CTRL_PERF_CNT_EN
module div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_div,
  input  logic [DATA_W-1:0] opdata1,
  input  logic [DATA_W-1:0] opdata2,
  input  logic              flush,
  input  logic              hold,
  output logic              stall_div,
  output logic [DATA_W-1:0] result_hi,
  output logic [DATA_W-1:0] result_lo,
  output logic              result_ready
`ifdef DIV_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_ZERO = 2'd1,
    BUSY     = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Magnitude of an operand; only negative values in signed mode are negated.
  // The most negative value maps to itself, which is its correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                input logic              is_signed);
    if (is_signed && v[DATA_W-1]) begin
      abs_val = ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      abs_val = v;
    end
  endfunction

  // Conditional two's-complement negation used for the final sign fix-up.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic              neg);
    if (neg) begin
      cond_neg = ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      cond_neg = v;
    end
  endfunction

  state_t            state_r, state_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] quo_r;      // holds the dividend magnitude and shifts in quotient bits
  logic [DATA_W-1:0] dvs_r;      // divisor magnitude
  logic [DATA_W-1:0] rem_r;      // partial remainder; always below the divisor
  logic              neg_q_r;    // quotient must be negated (operand signs differ)
  logic              neg_r_r;    // remainder must be negated (dividend negative)
  logic              stall_s;

  // One restoring iteration. The 33-bit shifted remainder cannot overflow the compare.
  logic [DATA_W:0]   rem_shift_s;
  logic [DATA_W:0]   diff_s;
  logic [DATA_W-1:0] rem_next_s;
  logic [DATA_W-1:0] quo_next_s;

  assign rem_shift_s = {rem_r, quo_r[DATA_W-1]};
  assign diff_s      = rem_shift_s - {1'b0, dvs_r};
  assign rem_next_s  = diff_s[DATA_W] ? rem_shift_s[DATA_W-1:0] : diff_s[DATA_W-1:0];
  assign quo_next_s  = {quo_r[DATA_W-2:0], ~diff_s[DATA_W]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and stall decode; flush overrides every state.
  always_comb begin
    state_next_s = state_r;
    stall_s      = 1'b0;
    if (flush) begin
      state_next_s = IDLE;
      stall_s      = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            stall_s      = 1'b1;
            state_next_s = (opdata2 == '0) ? DIV_ZERO : BUSY;
          end else begin
            state_next_s = IDLE;
          end
        end
        DIV_ZERO: begin
          stall_s      = 1'b1;
          state_next_s = DONE;
        end
        BUSY: begin
          stall_s = 1'b1;
          if (cnt_r == LAST_ITER) begin
            state_next_s = DONE;
          end else begin
            state_next_s = BUSY;
          end
        end
        DONE: begin
          if (hold) begin
            state_next_s = DONE;
          end else begin
            state_next_s = IDLE;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // Reset wins over a start seen in the same cycle.
  assign stall_div = stall_s & ~rst;

  // Operand latch, iteration datapath and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= '0;
      quo_r        <= '0;
      dvs_r        <= '0;
      rem_r        <= '0;
      neg_q_r      <= 1'b0;
      neg_r_r      <= 1'b0;
      result_hi    <= '0;
      result_lo    <= '0;
      result_ready <= 1'b0;
    end else if (flush) begin
      cnt_r        <= '0;
      result_hi    <= '0;
      result_lo    <= '0;
      result_ready <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            quo_r   <= abs_val(opdata1, signed_div);
            dvs_r   <= abs_val(opdata2, signed_div);
            rem_r   <= '0;
            cnt_r   <= '0;
            neg_q_r <= signed_div & (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
            neg_r_r <= signed_div & opdata1[DATA_W-1];
          end
        end
        DIV_ZERO: begin
          result_hi    <= '0;
          result_lo    <= '0;
          result_ready <= 1'b1;
        end
        BUSY: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_ITER) begin
            result_hi    <= cond_neg(rem_next_s, neg_r_r);
            result_lo    <= cond_neg(quo_next_s, neg_q_r);
            result_ready <= 1'b1;
          end
        end
        DONE: begin
          if (!hold) begin
            result_hi    <= '0;
            result_lo    <= '0;
            result_ready <= 1'b0;
          end
        end
        default: begin
          result_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef DIV_CTRL_PERF_CNT_EN
  // Saturating stall-cycle counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= 32'd0;
    end else if (stall_s && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed test-plan cases plus random
// divisions compared against an arithmetic reference model.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, signed_div, flush, hold;
  logic [31:0] opdata1, opdata2;
  logic        stall_div, result_ready;
  logic [31:0] result_hi, result_lo;
`ifdef DIV_CTRL_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_ctrl #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_div   (signed_div),
    .opdata1      (opdata1),
    .opdata2      (opdata2),
    .flush        (flush),
    .hold         (hold),
    .stall_div    (stall_div),
    .result_hi    (result_hi),
    .result_lo    (result_lo),
    .result_ready (result_ready)
`ifdef DIV_CTRL_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: {remainder, quotient} from plain 64-bit arithmetic
  // (truncating division, remainder follows the dividend's sign).
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // One complete division from an IDLE cycle, with optional DONE hold and
  // start kept high for the whole instruction.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold_n, input logic keep_start);
    logic [63:0] e;
    int lat;
    e   = model(sgn, a, b);
    lat = (b == 32'd0) ? 2 : 33;
    @(posedge clk); #1;
    start = 1'b1; signed_div = sgn; opdata1 = a; opdata2 = b; hold = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_eq("stall_at_T", {63'd0, stall_div}, 64'd1);
    check_eq("ready_at_T", {63'd0, result_ready}, 64'd0);
    for (int k = 1; k < lat; k++) begin
      @(posedge clk); #1;
      start = keep_start; opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom);
      @(negedge clk);
      check_eq("stall_busy", {63'd0, stall_div}, 64'd1);
      check_eq("ready_busy", {63'd0, result_ready}, 64'd0);
    end
    for (int i = 0; i <= hold_n; i++) begin
      @(posedge clk); #1;
      hold = (i < hold_n);
      @(negedge clk);
      check_eq("ready_done", {63'd0, result_ready}, 64'd1);
      check_eq("lo_done", {32'd0, result_lo}, {32'd0, e[31:0]});
      check_eq("hi_done", {32'd0, result_hi}, {32'd0, e[63:32]});
      check_eq("stall_done", {63'd0, stall_div}, 64'd0);
    end
    @(posedge clk); #1;
    hold = 1'b0; start = 1'b0;
    @(negedge clk);
    check_eq("ready_after", {63'd0, result_ready}, 64'd0);
    check_eq("lo_after", {32'd0, result_lo}, 64'd0);
    check_eq("hi_after", {32'd0, result_hi}, 64'd0);
    check_eq("stall_after", {63'd0, stall_div}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; flush = 1'b0; hold = 1'b0;
    opdata1 = 32'd0; opdata2 = 32'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_ready", {63'd0, result_ready}, 64'd0);
    check_eq("rst_lo", {32'd0, result_lo}, 64'd0);
    check_eq("rst_hi", {32'd0, result_hi}, 64'd0);
    check_eq("rst_stall", {63'd0, stall_div}, 64'd0);
`ifdef DIV_CTRL_PERF_CNT_EN
    check_eq("rst_perf", {32'd0, perf_stall_cnt}, 64'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases from the test plan.
    run_div(1'b0, 32'd100, 32'd7, 0, 1'b0);
`ifdef DIV_CTRL_PERF_CNT_EN
    check_eq("perf_one_div", {32'd0, perf_stall_cnt}, 64'd33);
`endif
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    run_div(1'b0, 32'd5, 32'd0, 0, 1'b0);
    run_div(1'b0, 32'd1000, 32'd33, 3, 1'b1);
    run_div(1'b1, 32'hFFFF_FF00, 32'd0, 2, 1'b1);

    // Flush mid-BUSY at T+10, then a fresh DIVU 9/3 at T+12.
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    @(negedge clk);
    check_eq("flush_stall_T", {63'd0, stall_div}, 64'd1);
    for (int k = 1; k < 10; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_stall_now", {63'd0, stall_div}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check_eq("flush_idle_stall", {63'd0, stall_div}, 64'd0);
    check_eq("flush_no_ready", {63'd0, result_ready}, 64'd0);
    run_div(1'b0, 32'd9, 32'd3, 0, 1'b0);

    // Flush while DONE is held: results must clear.
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd5; opdata2 = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    hold = 1'b1;
    @(negedge clk);
    check_eq("dz_ready", {63'd0, result_ready}, 64'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; hold = 1'b0;
    @(negedge clk);
    check_eq("flush_done_ready", {63'd0, result_ready}, 64'd0);
    check_eq("flush_done_stall", {63'd0, stall_div}, 64'd0);

    // Reset at T+5 mid-BUSY.
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b1; opdata1 = 32'd12345; opdata2 = 32'd11;
    for (int k = 1; k < 5; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstbusy_stall", {63'd0, stall_div}, 64'd0);
    check_eq("rstbusy_ready", {63'd0, result_ready}, 64'd0);
    check_eq("rstbusy_lo", {32'd0, result_lo}, 64'd0);
    check_eq("rstbusy_hi", {32'd0, result_hi}, 64'd0);
    for (int k = 0; k < 35; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("rstbusy_quiet", {63'd0, result_ready}, 64'd0);
    end
`ifdef DIV_CTRL_PERF_CNT_EN
    check_eq("perf_after_rst", {32'd0, perf_stall_cnt}, 64'd0);
    run_div(1'b0, 32'd77, 32'd5, 1, 1'b0);
    check_eq("perf_after_div", {32'd0, perf_stall_cnt}, 64'd33);
`endif

    // Random divisions.
    for (int n = 0; n < 30; n++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        default: b = $urandom;
      endcase
      run_div(1'($urandom), a, b, $urandom_range(0, 3), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
